// File: rtl/bram_byte_port_pkg.sv
// bram_byte_port_pkg: FSM state encoding and byte-lane width helper shared by the byte port
package bram_byte_port_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, MERGE = 2'd1, ACK = 2'd2} state_e;
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/bram_byte_port_bram.sv
// bram_byte_port_bram: single-port inferred bram, registered read, write-through on write
module bram_byte_port_bram #(
  parameter int memSize_p = 8,
  parameter int dataWidth_p = 32
) (
  input  logic                   clk_i,
  input  logic [memSize_p-1:0]   addr_i,
  input  logic                   write_i,
  input  logic [dataWidth_p-1:0] data_i,
  output logic [dataWidth_p-1:0] data_o
);
  logic [dataWidth_p-1:0] mem [2**memSize_p];
  always_ff @(posedge clk_i) begin
    if (write_i) begin
      mem[addr_i] <= data_i;
      data_o <= data_i;
    end else begin
      data_o <= mem[addr_i];
    end
  end
endmodule

// File: rtl/bram_byte_port.sv
// bram_byte_port: byte-strobed request/response front end; partial writes become read-modify-write
module bram_byte_port
  import bram_byte_port_pkg::*;
#(
  parameter int memSize_p = 8,
  parameter int dataWidth_p = 32,
  localparam int STRB_W = strb_w(dataWidth_p)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_write_i,
  input  logic [memSize_p-1:0]   req_addr_i,
  input  logic [STRB_W-1:0]      req_wstrb_i,
  input  logic [dataWidth_p-1:0] req_wdata_i,
  output logic                   rsp_valid_o,
  output logic [dataWidth_p-1:0] rsp_rdata_o
);
  state_e                 state_q, state_d;
  logic [memSize_p-1:0]   addr_q;
  logic [STRB_W-1:0]      strb_q;
  logic [dataWidth_p-1:0] wdata_q;
  logic                   rsp_valid_q;
  logic                   accept, full, partial;
  logic [memSize_p-1:0]   mem_addr;
  logic                   mem_write;
  logic [dataWidth_p-1:0] mem_wdata, mem_rdata, merged;
  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;
  assign full        = &req_wstrb_i;
  assign partial     = req_write_i && !full && |req_wstrb_i;
  assign mem_addr    = (state_q == MERGE) ? addr_q : req_addr_i;
  // a zero strobe falls through as a read; rst_i drops any in-flight merge write
  assign mem_write   = !rst_i && ((accept && req_write_i && full) || state_q == MERGE);
  assign mem_wdata   = (state_q == MERGE) ? merged : req_wdata_i;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = mem_rdata;
  always_comb begin
    merged = mem_rdata;
    for (int k = 0; k < STRB_W; k++)
      merged[8*k +: 8] = strb_q[k] ? wdata_q[8*k +: 8] : mem_rdata[8*k +: 8];
  end
  always_comb
    state_d = (state_q == IDLE)  ? (accept ? (partial ? MERGE : ACK) : IDLE) :
              (state_q == MERGE) ? ACK : IDLE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      strb_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= (state_d == ACK);
      if (accept) begin
        addr_q  <= req_addr_i;
        strb_q  <= req_wstrb_i;
        wdata_q <= req_wdata_i;
      end
    end
  end
  bram_byte_port_bram #(.memSize_p(memSize_p), .dataWidth_p(dataWidth_p)) u_bram (
    .clk_i  (clk_i),
    .addr_i (mem_addr),
    .write_i(mem_write),
    .data_i (mem_wdata),
    .data_o (mem_rdata)
  );
endmodule

// File: tb/tb_bram_byte_port.sv
// tb_bram_byte_port: table-driven directed checks plus back-to-back and reset-during-merge sequences
module tb_bram_byte_port;
  logic        clk = 0;
  logic        rst = 1;
  logic        req_valid = 0;
  logic        req_ready;
  logic        req_write = 0;
  logic [3:0]  req_addr = 0;
  logic [3:0]  req_wstrb = 0;
  logic [31:0] req_wdata = 0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  int checks = 0;
  int failures = 0;
  logic [31:0] rsp_q[$];
  always #5 clk = ~clk;
  bram_byte_port #(.memSize_p(4), .dataWidth_p(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr),
    .req_wstrb_i(req_wstrb), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata)
  );
  always @(negedge clk) if (rsp_valid) rsp_q.push_back(rsp_rdata);
  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;
  vec_t vecs[13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask
  task automatic xfer(input logic wr, input logic [3:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] got, output int lat);
    @(negedge clk);
    req_valid = 1; req_write = wr; req_addr = a; req_wstrb = s; req_wdata = d;
    wait_ready("xfer");
    @(posedge clk);
    #1;
    req_valid = 0;
    req_wdata = ~d;
    lat = 1;
    while (!rsp_valid && lat < 6) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = rsp_rdata;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] got;
    int lat;
    logic [31:0] b2b_req[4][4];
    logic [31:0] b2b_exp[4];
    vecs[0]  = '{1, 4'd3,  4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 1};
    vecs[1]  = '{0, 4'd3,  4'h0, 32'h0,        32'hDEADBEEF, 1};
    vecs[2]  = '{1, 4'd5,  4'hF, 32'h11223344, 32'h11223344, 1};
    vecs[3]  = '{1, 4'd5,  4'h2, 32'h0000AA00, 32'h1122AA44, 2};
    vecs[4]  = '{0, 4'd5,  4'h0, 32'h0,        32'h1122AA44, 1};
    vecs[5]  = '{1, 4'd5,  4'h0, 32'hFFFFFFFF, 32'h1122AA44, 1};
    vecs[6]  = '{0, 4'd5,  4'hF, 32'h0,        32'h1122AA44, 1};
    vecs[7]  = '{1, 4'd15, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D, 1};
    vecs[8]  = '{1, 4'd0,  4'hF, 32'h01020304, 32'h01020304, 1};
    vecs[9]  = '{0, 4'd15, 4'h0, 32'h0,        32'hCAFEF00D, 1};
    vecs[10] = '{0, 4'd0,  4'h0, 32'h0,        32'h01020304, 1};
    vecs[11] = '{1, 4'd0,  4'h9, 32'hAABBCCDD, 32'hAA0203DD, 2};
    vecs[12] = '{1, 4'd7,  4'hF, 32'h55555555, 32'h55555555, 1};
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_ready_low", {31'd0, req_ready}, 32'd0);
    rst = 0;
    @(negedge clk);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    for (int i = 0; i < 13; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].strb, vecs[i].wdata, got, lat);
      chk($sformatf("vec%0d_rdata", i), got, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
    end
    // back-to-back: valid held high, fields swapped only after each acceptance
    b2b_req[0] = '{1, 1, 4'hF, 32'h10203040};
    b2b_req[1] = '{0, 1, 4'h0, 32'hFFFFFFFF};
    b2b_req[2] = '{1, 1, 4'h2, 32'h00005500};
    b2b_req[3] = '{0, 1, 4'hF, 32'h0};
    b2b_exp = '{32'h10203040, 32'h10203040, 32'h10205540, 32'h10205540};
    repeat (3) @(negedge clk);
    rsp_q.delete();
    req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      req_write = b2b_req[i][0][0];
      req_addr  = b2b_req[i][1][3:0];
      req_wstrb = b2b_req[i][2][3:0];
      req_wdata = b2b_req[i][3];
      wait_ready("b2b");
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b%0d_ready_busy", i), {31'd0, req_ready}, 32'd0);
    end
    req_valid = 0;
    repeat (4) @(negedge clk);
    chk("b2b_rsp_count", rsp_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("b2b%0d_rdata", i), (i < rsp_q.size()) ? rsp_q[i] : 32'hXXXXXXXX, b2b_exp[i]);
    // reset asserted during the MERGE cycle of a partial write to addr 7
    rsp_q.delete();
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 4'd7; req_wstrb = 4'h1; req_wdata = 32'h000000FF;
    wait_ready("rst_merge");
    @(posedge clk);
    #1;
    req_valid = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    repeat (4) @(negedge clk);
    chk("rst_merge_no_rsp", rsp_q.size(), 0);
    xfer(0, 4'd7, 4'h0, 32'h0, got, lat);
    chk("rst_merge_addr7", got, 32'h55555555);
    chk("rst_merge_read_lat", lat, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
